// File: rtl/agu_arbiter.sv
// agu_arbiter: shares one effective-address unit between a load/store requester
// (A) and a branch/jump requester (B). B has priority, and a starvation counter
// forces A to win after STARVE_LIMIT consecutive lost contentions. The result
// sits in a one-entry output register with a valid/ready handshake.
// Optional feature macro: AGU_ARB_PERF_EN adds saturating grant/stall counters.
module agu_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [3:0]       i_a_op,
  input  logic [31:0]      i_a_addr,
  input  logic [25:0]      i_a_offset,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [3:0]       i_b_op,
  input  logic [31:0]      i_b_addr,
  input  logic [25:0]      i_b_offset,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_id,
  output logic [31:0]      o_res_addr,
  output logic [1:0]       o_res_exc,
  output logic             o_res_illegal
`ifdef AGU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] o_perf_grant_a,
  output logic [CNT_W-1:0] o_perf_grant_b,
  output logic [CNT_W-1:0] o_perf_stall
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  // Elaboration-time guard: a zero limit or zero-width counter is meaningless.
  if (STARVE_LIMIT == 0 || CNT_W == 0) begin : g_bad_params
    $error("agu_arbiter: STARVE_LIMIT and CNT_W must both be >= 1");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [1:0]  exc;
    logic        illegal;
  } result_t;

  // Effective-address computation for one request; all sums wrap mod 2^32.
  function automatic result_t agu_calc(input logic        id,
                                       input logic [3:0]  op,
                                       input logic [31:0] base,
                                       input logic [25:0] offset);
    result_t     res;
    logic [31:0] s16;
    logic [31:0] sum;
    res     = '0;
    res.id  = id;
    s16     = {{16{offset[15]}}, offset[15:0]};
    sum     = base + s16;
    case (op)
      4'd1: begin
        res.addr = sum;
        res.exc  = sum[1:0];
      end
      4'd2:    res.addr = base + {s16[29:0], 2'b00};
      4'd3:    res.addr = {base[31:28], offset, 2'b00};
      default: res.illegal = 1'b1;
    endcase
    return res;
  endfunction

  state_t                state_q;
  state_t                state_d;
  result_t               res_q;
  result_t               res_d;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  accept_ok;
  logic                  starved;
  logic                  grant_a;
  logic                  grant_b;
  logic                  grant;
  logic                  contention;

  assign accept_ok  = (state_q == EMPTY) | i_res_ready;
  assign starved    = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign contention = i_a_valid & i_b_valid;

  // Per-cycle grant: B wins contention unless A has been starved out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (accept_ok) begin
      if (contention) begin
        grant_a = starved;
        grant_b = !starved;
      end else begin
        grant_a = i_a_valid;
        grant_b = i_b_valid;
      end
    end
  end

  assign grant     = grant_a | grant_b;
  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;

  // Result of the winning request, ready to load into the output register.
  always_comb begin
    res_d = grant_a ? agu_calc(1'b0, i_a_op, i_a_addr, i_a_offset)
                    : agu_calc(1'b1, i_b_op, i_b_addr, i_b_offset);
  end

  // Output-register occupancy: a grant always fills it, a drain without grant empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (i_res_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset drops any result in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    if (!i_rst_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Result payload register; only loads on a grant so fields are stable while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the payload is reset too because its fields are visible outputs that must read 0 after reset.
    if (!i_rst_n)   res_q <= '0;
    else if (grant) res_q <= res_d;
  end

  // Starvation counter: counts A's lost contentions, cleared whenever A wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (grant_a) begin
      starve_cnt <= '0;
    end else if (contention && grant_b && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign o_res_valid   = (state_q == FULL);
  assign o_res_id      = res_q.id;
  assign o_res_addr    = res_q.addr;
  assign o_res_exc     = res_q.exc;
  assign o_res_illegal = res_q.illegal;

`ifdef AGU_ARB_PERF_EN
  logic [CNT_W-1:0] perf_ga;
  logic [CNT_W-1:0] perf_gb;
  logic [CNT_W-1:0] perf_st;
  logic             stall;

  assign stall = (i_a_valid | i_b_valid) & !grant;

  // Saturating performance counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_ga <= '0;
      perf_gb <= '0;
      perf_st <= '0;
    end else begin
      if (grant_a && !(&perf_ga)) perf_ga <= perf_ga + 1'b1;
      if (grant_b && !(&perf_gb)) perf_gb <= perf_gb + 1'b1;
      if (stall   && !(&perf_st)) perf_st <= perf_st + 1'b1;
    end
  end

  assign o_perf_grant_a = perf_ga;
  assign o_perf_grant_b = perf_gb;
  assign o_perf_stall   = perf_st;
`endif

endmodule

// File: tb/tb_agu_arbiter.sv
// Self-checking bench for agu_arbiter: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Build with +define+AGU_ARB_PERF_EN to also check the performance counters.
module tb_agu_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, res_ready;
  logic [3:0]  a_op, b_op;
  logic [31:0] a_addr, b_addr;
  logic [25:0] a_offset, b_offset;
  logic        a_ready, b_ready;
  logic        res_valid, res_id, res_illegal;
  logic [31:0] res_addr;
  logic [1:0]  res_exc;
`ifdef AGU_ARB_PERF_EN
  logic [CW-1:0] perf_ga, perf_gb, perf_st;
`endif

  int total = 0;
  int bad   = 0;
  bit en_cmp = 0;

  agu_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_a_valid     (a_valid),
    .o_a_ready     (a_ready),
    .i_a_op        (a_op),
    .i_a_addr      (a_addr),
    .i_a_offset    (a_offset),
    .i_b_valid     (b_valid),
    .o_b_ready     (b_ready),
    .i_b_op        (b_op),
    .i_b_addr      (b_addr),
    .i_b_offset    (b_offset),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_id      (res_id),
    .o_res_addr    (res_addr),
    .o_res_exc     (res_exc),
    .o_res_illegal (res_illegal)
`ifdef AGU_ARB_PERF_EN
    ,
    .o_perf_grant_a(perf_ga),
    .o_perf_grant_b(perf_gb),
    .o_perf_stall  (perf_st)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_valid;
  bit        m_id;
  bit [31:0] m_addr;
  bit [1:0]  m_exc;
  bit        m_ill;
  int        m_starve;
  int        m_ga, m_gb, m_st;

  // Which requester the rules pick this cycle: 0 none, 1 A, 2 B.
  function automatic int pick();
    if (m_valid && !res_ready) return 0;
    if (a_valid && b_valid)    return (m_starve == LIMIT) ? 1 : 2;
    if (a_valid)               return 1;
    if (b_valid)               return 2;
    return 0;
  endfunction

  function automatic void calc(input bit [3:0] op, input bit [31:0] base, input bit [25:0] off,
                               output bit [31:0] ea, output bit [1:0] exc, output bit ill);
    int signed s;
    s   = int'(shortint'(off[15:0]));
    ea  = 0;
    exc = 0;
    ill = 0;
    if (op == 1) begin
      ea  = base + 32'(s);
      exc = ea[1:0];
    end else if (op == 2) begin
      ea = base + 32'(s * 4);
    end else if (op == 3) begin
      ea = (base & 32'hF000_0000) | (32'(off) << 2);
    end else begin
      ill = 1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_addr = 0; m_exc = 0; m_ill = 0;
      m_starve = 0; m_ga = 0; m_gb = 0; m_st = 0;
    end else begin
      int w;
      w = pick();
      if (w == 0 && (a_valid || b_valid) && m_st < 65535) m_st++;
      if (w == 1) begin
        calc(a_op, a_addr, a_offset, m_addr, m_exc, m_ill);
        m_id = 0; m_valid = 1; m_starve = 0;
        if (m_ga < 65535) m_ga++;
      end else if (w == 2) begin
        calc(b_op, b_addr, b_offset, m_addr, m_exc, m_ill);
        m_id = 1; m_valid = 1;
        if (a_valid && m_starve < LIMIT) m_starve++;
        if (m_gb < 65535) m_gb++;
      end else if (res_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (en_cmp) begin
      int w;
      w = pick();
      check("cyc_a_ready",  32'(a_ready),     32'(w == 1));
      check("cyc_b_ready",  32'(b_ready),     32'(w == 2));
      check("cyc_valid",    32'(res_valid),   32'(m_valid));
      check("cyc_id",       32'(res_id),      32'(m_id));
      check("cyc_addr",     res_addr,         m_addr);
      check("cyc_exc",      32'(res_exc),     32'(m_exc));
      check("cyc_illegal",  32'(res_illegal), 32'(m_ill));
`ifdef AGU_ARB_PERF_EN
      check("cyc_perf_ga",  32'(perf_ga), 32'(m_ga));
      check("cyc_perf_gb",  32'(perf_gb), 32'(m_gb));
      check("cyc_perf_st",  32'(perf_st), 32'(m_st));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input bit [3:0] op, input bit [31:0] ad, input bit [25:0] off);
    a_valid = v; a_op = op; a_addr = ad; a_offset = off;
  endtask

  task automatic set_b(input bit v, input bit [3:0] op, input bit [31:0] ad, input bit [25:0] off);
    b_valid = v; b_op = op; b_addr = ad; b_offset = off;
  endtask

  function automatic bit [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] snap;

  initial begin
    rst_n = 0;
    res_ready = 1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    en_cmp = 1;
    #1;
    check("rst_valid", 32'(res_valid), 0);
    check("rst_addr",  res_addr,       0);

    // A only, op1 with negative offset: 0x1000 - 2.
    set_a(1, 4'd1, 32'h1000, 26'h0FFFE);
    #1 check("t1_a_ready", 32'(a_ready), 1);
    step();
    set_a(0, 0, 0, 0);
    check("t1_valid", 32'(res_valid), 1);
    check("t1_addr",  res_addr,       32'h0000_0FFE);
    check("t1_exc",   32'(res_exc),   2);
    check("t1_id",    32'(res_id),    0);

    // Wrap-around: 0xFFFF_FFFC + 4 -> 0.
    set_a(1, 4'd1, 32'hFFFF_FFFC, 26'h4);
    step();
    set_a(0, 0, 0, 0);
    check("wrap_addr", res_addr,     32'h0);
    check("wrap_exc",  32'(res_exc), 0);

    // B only: op3 then op2.
    set_b(1, 4'd3, 32'hA000_0000, 26'h10);
    step();
    check("t2_op3_addr", res_addr,    32'hA000_0040);
    check("t2_op3_id",   32'(res_id), 1);
    set_b(1, 4'd2, 32'h100, 26'h0FFFF);
    step();
    set_b(0, 0, 0, 0);
    check("t2_op2_addr", res_addr, 32'h0000_00FC);

    // Continuous contention: B,B,B,B,A repeating.
    set_a(1, 4'd1, 32'h2000, 26'h0);
    set_b(1, 4'd1, 32'h3000, 26'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_grant_a", 32'(a_ready), 32'(i % 5 == 4));
      check("t3_grant_b", 32'(b_ready), 32'(i % 5 != 4));
      step();
    end

    // Stall three cycles, then drain and reload in the same cycle.
    snap = res_addr;
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_a_ready", 32'(a_ready),   0);
      check("t4_b_ready", 32'(b_ready),   0);
      check("t4_valid",   32'(res_valid), 1);
      check("t4_stable",  res_addr,       snap);
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(1, 4'd3, 32'h5000_0000, 26'h21);
    res_ready = 1;
    #1 check("t4_b_ready_drain", 32'(b_ready), 1);
    step();
    check("t4_reload_valid", 32'(res_valid), 1);
    check("t4_reload_addr",  res_addr,       32'h5000_0084);

    // Build up starvation, then reset with a result held.
    set_a(1, 4'd1, 32'h10, 26'h0);
    set_b(1, 4'd1, 32'h20, 26'h0);
    step();
    step();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    rst_n = 0;
    #1;
    check("t5_valid",   32'(res_valid),   0);
    check("t5_id",      32'(res_id),      0);
    check("t5_addr",    res_addr,         0);
    check("t5_exc",     32'(res_exc),     0);
    check("t5_illegal", 32'(res_illegal), 0);
    step();
    rst_n = 1;
    set_a(1, 4'd1, 32'h10, 26'h0);
    set_b(1, 4'd1, 32'h20, 26'h0);
    for (int i = 0; i < 5; i++) begin
      #1 check("t5_post_grant_a", 32'(a_ready), 32'(i == 4));
      step();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);

    // Illegal op after a fresh reset.
    rst_n = 0;
    step();
    rst_n = 1;
    set_a(1, 4'd7, 32'h1234, 26'h55);
    #1 check("t6_a_ready", 32'(a_ready), 1);
    step();
    set_a(0, 0, 0, 0);
    check("t6_illegal", 32'(res_illegal), 1);
    check("t6_addr",    res_addr,         0);
    check("t6_exc",     32'(res_exc),     0);
`ifdef AGU_ARB_PERF_EN
    check("t6_perf_ga", 32'(perf_ga), 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] opa, opb;
      opa = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      opb = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
      set_a($urandom_range(0, 2) != 0, opa, rand_addr(), 26'($urandom));
      set_b($urandom_range(0, 1) != 0, opb, rand_addr(), 26'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    en_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
